// File: rtl/rx_header_parser.sv
// RDMA receive header parser: strips a 7-beat header, latches its fields, passes the payload through.
// Optional payload-length check against hdr_length is enabled with `define RX_HDR_LEN_CHECK_EN.
module rx_header_parser #(
  parameter int unsigned C_AXIS_TDATA_WIDTH = 32,
  parameter int unsigned C_AXIS_TKEEP_WIDTH = 4
) (
  input  logic                          aclk,
  input  logic                          aresetn,
  input  logic [C_AXIS_TDATA_WIDTH-1:0] s_axis_tdata,
  input  logic [C_AXIS_TKEEP_WIDTH-1:0] s_axis_tkeep,
  input  logic                          s_axis_tvalid,
  input  logic                          s_axis_tlast,
  output logic                          s_axis_tready,
  output logic [C_AXIS_TDATA_WIDTH-1:0] m_axis_tdata,
  output logic [C_AXIS_TKEEP_WIDTH-1:0] m_axis_tkeep,
  output logic                          m_axis_tvalid,
  output logic                          m_axis_tlast,
  input  logic                          m_axis_tready,
  output logic [7:0]                    hdr_opcode,
  output logic [23:0]                   hdr_psn,
  output logic [23:0]                   hdr_dest_qp,
  output logic [31:0]                   hdr_remote_addr,
  output logic [15:0]                   hdr_frag_offset,
  output logic [31:0]                   hdr_length,
  output logic [15:0]                   hdr_pkey,
  output logic [7:0]                    hdr_service_level,
  output logic                          hdr_valid,
  output logic                          pkt_done,
  output logic                          hdr_error,
  output logic                          len_error,
  output logic                          rx_busy,
  output logic [15:0]                   pkt_count
);

  localparam logic [23:0] MARKER = 24'hABABAB;

  typedef enum logic [1:0] {IDLE, HDR, DATA, DROP} state_t;

  state_t     state;
  logic [2:0] beat_cnt;

  logic in_data, s_hs, hs_b6, marker_ok, zero_pay, data_last, done_now, len_bad;

  // Payload is forwarded combinationally in DATA; everything is quiet elsewhere.
  assign in_data       = (state == DATA);
  assign s_axis_tready = (state == HDR) || (state == DROP) || (in_data && m_axis_tready);
  assign m_axis_tvalid = in_data && s_axis_tvalid;
  assign m_axis_tdata  = in_data ? s_axis_tdata : '0;
  assign m_axis_tkeep  = in_data ? s_axis_tkeep : '0;
  assign m_axis_tlast  = in_data && s_axis_tlast;
  assign rx_busy       = (state != IDLE);

  assign s_hs      = s_axis_tvalid && s_axis_tready;
  assign hs_b6     = (state == HDR) && s_hs && (beat_cnt == 3'd6);
  assign marker_ok = (s_axis_tdata[31:8] == MARKER);
  assign zero_pay  = hs_b6 && marker_ok && s_axis_tlast;
  assign data_last = in_data && s_hs && s_axis_tlast;
  assign done_now  = data_last || zero_pay;

`ifdef RX_HDR_LEN_CHECK_EN
  logic [31:0] pay_cnt;

  // Count includes the tlast beat being accepted this cycle.
  assign len_bad = (data_last && ((pay_cnt + 32'd1) != hdr_length)) ||
                   (zero_pay && (hdr_length != 32'd0));

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      pay_cnt   <= '0;
      len_error <= 1'b0;
    end else begin
      len_error <= done_now && len_bad;
      if (state == HDR)
        pay_cnt <= '0;
      else if (in_data && s_hs)
        pay_cnt <= pay_cnt + 32'd1;
    end
  end
`else
  assign len_bad   = 1'b0;
  assign len_error = 1'b0;
`endif

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state             <= IDLE;
      beat_cnt          <= '0;
      hdr_opcode        <= '0;
      hdr_psn           <= '0;
      hdr_dest_qp       <= '0;
      hdr_remote_addr   <= '0;
      hdr_frag_offset   <= '0;
      hdr_length        <= '0;
      hdr_pkey          <= '0;
      hdr_service_level <= '0;
      hdr_valid         <= 1'b0;
      hdr_error         <= 1'b0;
      pkt_done          <= 1'b0;
      pkt_count         <= '0;
    end else begin
      hdr_valid <= 1'b0;
      hdr_error <= 1'b0;
      pkt_done  <= done_now;
      if (done_now && !len_bad)
        pkt_count <= pkt_count + 16'd1;

      case (state)
        IDLE: begin
          if (s_axis_tvalid) begin
            state    <= HDR;
            beat_cnt <= '0;
          end
        end
        HDR: begin
          if (s_hs) begin
            beat_cnt <= beat_cnt + 3'd1;
            // A truncated header leaves the field of its tlast beat untouched.
            if ((beat_cnt != 3'd6) && s_axis_tlast) begin
              hdr_error <= 1'b1;
              state     <= IDLE;
            end else begin
              case (beat_cnt)
                3'd0: begin
                  hdr_psn    <= s_axis_tdata[31:8];
                  hdr_opcode <= s_axis_tdata[7:0];
                end
                3'd1: hdr_dest_qp     <= s_axis_tdata[23:0];
                3'd2: hdr_remote_addr <= s_axis_tdata[31:0];
                3'd3: hdr_frag_offset <= s_axis_tdata[15:0];
                3'd4: hdr_length      <= s_axis_tdata[31:0];
                3'd5: hdr_pkey        <= s_axis_tdata[15:0];
                3'd6: begin
                  hdr_service_level <= s_axis_tdata[7:0];
                  if (marker_ok) begin
                    hdr_valid <= 1'b1;
                    state     <= s_axis_tlast ? IDLE : DATA;
                  end else begin
                    hdr_error <= 1'b1;
                    state     <= s_axis_tlast ? IDLE : DROP;
                  end
                end
                default: ;
              endcase
            end
          end
        end
        DATA: begin
          if (s_hs && s_axis_tlast)
            state <= IDLE;
        end
        DROP: begin
          if (s_hs && s_axis_tlast)
            state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rx_header_parser.sv
// Directed self-checking bench for rx_header_parser; inputs change on negedge, outputs sampled mid-cycle.
module tb_rx_header_parser;

  logic        aclk = 1'b0;
  logic        aresetn;
  logic [31:0] s_axis_tdata;
  logic [3:0]  s_axis_tkeep;
  logic        s_axis_tvalid, s_axis_tlast, s_axis_tready;
  logic [31:0] m_axis_tdata;
  logic [3:0]  m_axis_tkeep;
  logic        m_axis_tvalid, m_axis_tlast, m_axis_tready;
  logic [7:0]  hdr_opcode, hdr_service_level;
  logic [23:0] hdr_psn, hdr_dest_qp;
  logic [31:0] hdr_remote_addr, hdr_length;
  logic [15:0] hdr_frag_offset, hdr_pkey, pkt_count;
  logic        hdr_valid, pkt_done, hdr_error, len_error, rx_busy;

  rx_header_parser dut (
    .aclk(aclk), .aresetn(aresetn),
    .s_axis_tdata(s_axis_tdata), .s_axis_tkeep(s_axis_tkeep), .s_axis_tvalid(s_axis_tvalid),
    .s_axis_tlast(s_axis_tlast), .s_axis_tready(s_axis_tready),
    .m_axis_tdata(m_axis_tdata), .m_axis_tkeep(m_axis_tkeep), .m_axis_tvalid(m_axis_tvalid),
    .m_axis_tlast(m_axis_tlast), .m_axis_tready(m_axis_tready),
    .hdr_opcode(hdr_opcode), .hdr_psn(hdr_psn), .hdr_dest_qp(hdr_dest_qp),
    .hdr_remote_addr(hdr_remote_addr), .hdr_frag_offset(hdr_frag_offset), .hdr_length(hdr_length),
    .hdr_pkey(hdr_pkey), .hdr_service_level(hdr_service_level),
    .hdr_valid(hdr_valid), .pkt_done(pkt_done), .hdr_error(hdr_error), .len_error(len_error),
    .rx_busy(rx_busy), .pkt_count(pkt_count)
  );

  always #5 aclk = ~aclk;

  int n_chk = 0, n_pass = 0;
  int n_hv, n_he, n_pd, n_le, n_both;
  bit mv_seen;
  logic [36:0] outq[$];
  logic [31:0] stim_d[0:15];
  logic [3:0]  stim_k[0:15];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Mid-cycle observer of pulses and output handshakes.
  always @(negedge aclk) begin
    #2;
    if (aresetn) begin
      if (hdr_valid) n_hv++;
      if (hdr_error) n_he++;
      if (pkt_done) n_pd++;
      if (len_error) n_le++;
      if (pkt_done && len_error) n_both++;
      if (m_axis_tvalid) mv_seen = 1'b1;
      if (m_axis_tvalid && m_axis_tready)
        outq.push_back({m_axis_tlast, m_axis_tkeep, m_axis_tdata});
    end
  end

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic clear_counts();
    n_hv = 0; n_he = 0; n_pd = 0; n_le = 0; n_both = 0; mv_seen = 1'b0;
    outq.delete();
  endtask

  task automatic load_hdr(input logic [23:0] psn, input logic [7:0] op, input logic [23:0] qp,
                          input logic [31:0] addr, input logic [15:0] frag, input logic [31:0] len,
                          input logic [15:0] pkey, input logic [31:0] b6);
    stim_d[0] = {psn, op};
    stim_d[1] = {8'h00, qp};
    stim_d[2] = addr;
    stim_d[3] = {16'h0000, frag};
    stim_d[4] = len;
    stim_d[5] = {16'h0000, pkey};
    stim_d[6] = b6;
    for (int i = 0; i < 7; i++) stim_k[i] = 4'hF;
  endtask

  task automatic set_payload(input int n, input logic [31:0] base);
    for (int i = 0; i < n; i++) begin
      stim_d[7+i] = base + 32'(i);
      stim_k[7+i] = (i == n - 1) ? 4'h3 : 4'hF;
    end
  endtask

  task automatic send(input int n, input bit toggle, input bit last_en);
    int i = 0;
    int budget = 0;
    while (i < n && budget < 200) begin
      @(negedge aclk);
      s_axis_tvalid = 1'b1;
      s_axis_tdata  = stim_d[i];
      s_axis_tkeep  = stim_k[i];
      s_axis_tlast  = last_en && (i == n - 1);
      if (toggle) m_axis_tready = ~m_axis_tready;
      #1;
      if (s_axis_tready) i++;
      budget++;
    end
    check("frame_accepted", 64'(i), 64'(n));
    @(negedge aclk);
    s_axis_tvalid = 1'b0;
    s_axis_tlast  = 1'b0;
    m_axis_tready = 1'b1;
    repeat (3) @(negedge aclk);
  endtask

  task automatic check_payload(input int n);
    check("payload_beats", 64'(outq.size()), 64'(n));
    for (int i = 0; i < n; i++)
      if (i < outq.size())
        check("payload_beat", 64'(outq[i]), 64'({(i == n - 1), stim_k[7+i], stim_d[7+i]}));
  endtask

  initial begin
    aresetn = 1'b0; s_axis_tvalid = 1'b0; s_axis_tlast = 1'b0;
    s_axis_tdata = '0; s_axis_tkeep = '0; m_axis_tready = 1'b1;
    clear_counts();
    repeat (2) @(negedge aclk);
    #1;
    check("rst_busy", 64'(rx_busy), 64'(0));
    check("rst_count", 64'(pkt_count), 64'(0));
    check("rst_tready", 64'(s_axis_tready), 64'(0));
    check("rst_hv", 64'(hdr_valid), 64'(0));
    @(negedge aclk); aresetn = 1'b1;

    // Basic good packet
    load_hdr(24'h000123, 8'h0A, 24'h000042, 32'h0000_1000, 16'h0007, 32'd3, 16'hFFFF, 32'hABABAB05);
    set_payload(3, 32'hD000_0001);
    clear_counts(); send(10, 1'b0, 1'b1);
    check("t1_hv", 64'(n_hv), 64'(1));
    check("t1_he", 64'(n_he), 64'(0));
    check("t1_pd", 64'(n_pd), 64'(1));
    check("t1_le", 64'(n_le), 64'(0));
    check_payload(3);
    check("t1_count", 64'(pkt_count), 64'(1));
    check("t1_op", 64'(hdr_opcode), 64'(8'h0A));
    check("t1_psn", 64'(hdr_psn), 64'(24'h000123));
    check("t1_qp", 64'(hdr_dest_qp), 64'(24'h000042));
    check("t1_addr", 64'(hdr_remote_addr), 64'(32'h1000));
    check("t1_frag", 64'(hdr_frag_offset), 64'(16'h0007));
    check("t1_len", 64'(hdr_length), 64'(3));
    check("t1_pkey", 64'(hdr_pkey), 64'(16'hFFFF));
    check("t1_sl", 64'(hdr_service_level), 64'(8'h05));
    check("t1_idle", 64'(rx_busy), 64'(0));

    // Same packet under downstream backpressure
    set_payload(3, 32'h5A00_0010);
    clear_counts(); send(10, 1'b1, 1'b1);
    check_payload(3);
    check("t2_pd", 64'(n_pd), 64'(1));
    check("t2_count", 64'(pkt_count), 64'(2));

    // Bad marker: whole packet dropped
    stim_d[6] = 32'h1234_5605;
    set_payload(4, 32'hBAD0_0000);
    clear_counts(); send(11, 1'b0, 1'b1);
    check("t3_he", 64'(n_he), 64'(1));
    check("t3_hv", 64'(n_hv), 64'(0));
    check("t3_mvalid", 64'(mv_seen), 64'(0));
    check("t3_pd", 64'(n_pd), 64'(0));
    check("t3_count", 64'(pkt_count), 64'(2));
    check("t3_idle", 64'(rx_busy), 64'(0));
    stim_d[6] = 32'hABAB_AB05;
    set_payload(3, 32'h0000_0C01);
    clear_counts(); send(10, 1'b0, 1'b1);
    check("t3b_hv", 64'(n_hv), 64'(1));
    check_payload(3);
    check("t3b_count", 64'(pkt_count), 64'(3));

    // Header truncated at beat3
    load_hdr(24'h0000AA, 8'h22, 24'h000001, 32'h2, 16'h3, 32'd3, 16'h5, 32'hABABAB06);
    clear_counts(); send(4, 1'b0, 1'b1);
    check("t4_he", 64'(n_he), 64'(1));
    check("t4_hv", 64'(n_hv), 64'(0));
    check("t4_idle", 64'(rx_busy), 64'(0));
    load_hdr(24'h000777, 8'h11, 24'h000099, 32'hCAFE_0000, 16'h0001, 32'd2, 16'h1234, 32'hABABAB07);
    set_payload(2, 32'h7700_0000);
    clear_counts(); send(9, 1'b0, 1'b1);
    check("t4b_hv", 64'(n_hv), 64'(1));
    check("t4b_psn", 64'(hdr_psn), 64'(24'h000777));
    check("t4b_op", 64'(hdr_opcode), 64'(8'h11));
    check("t4b_sl", 64'(hdr_service_level), 64'(8'h07));
    check_payload(2);
    check("t4b_count", 64'(pkt_count), 64'(4));

    // Zero-length payload: tlast on beat6
    load_hdr(24'h000500, 8'h0C, 24'h000003, 32'h0, 16'h0, 32'd0, 16'h0, 32'hABABAB09);
    clear_counts(); send(7, 1'b0, 1'b1);
    check("t5_hv", 64'(n_hv), 64'(1));
    check("t5_pd", 64'(n_pd), 64'(1));
    check("t5_le", 64'(n_le), 64'(0));
    check("t5_out", 64'(outq.size()), 64'(0));
    check("t5_count", 64'(pkt_count), 64'(5));

    // Reset after beat2, then a fresh packet parses from beat0
    load_hdr(24'h0BEEF0, 8'h33, 24'h000008, 32'h9, 16'h0, 32'd3, 16'h0, 32'hABABAB01);
    send(3, 1'b0, 1'b0);
    check("t6_busy_mid", 64'(rx_busy), 64'(1));
    @(negedge aclk); aresetn = 1'b0; s_axis_tvalid = 1'b1;
    #1;
    check("t6_rst_count", 64'(pkt_count), 64'(0));
    check("t6_rst_psn", 64'(hdr_psn), 64'(0));
    check("t6_rst_op", 64'(hdr_opcode), 64'(0));
    check("t6_rst_busy", 64'(rx_busy), 64'(0));
    check("t6_rst_tready", 64'(s_axis_tready), 64'(0));
    check("t6_rst_mvalid", 64'(m_axis_tvalid), 64'(0));
    @(negedge aclk); s_axis_tvalid = 1'b0; aresetn = 1'b1;
    load_hdr(24'h000456, 8'h0B, 24'h000077, 32'h4000, 16'h0002, 32'd3, 16'h00AA, 32'hABABAB02);
    set_payload(3, 32'h4560_0000);
    clear_counts(); send(10, 1'b0, 1'b1);
    check("t6_hv", 64'(n_hv), 64'(1));
    check("t6_psn", 64'(hdr_psn), 64'(24'h000456));
    check("t6_op", 64'(hdr_opcode), 64'(8'h0B));
    check("t6_qp", 64'(hdr_dest_qp), 64'(24'h000077));
    check_payload(3);
    check("t6_count", 64'(pkt_count), 64'(1));

`ifdef RX_HDR_LEN_CHECK_EN
    // Header says 4 beats, only 2 arrive
    load_hdr(24'h000888, 8'h0D, 24'h000004, 32'h0, 16'h0, 32'd4, 16'h0, 32'hABABAB03);
    set_payload(2, 32'h8880_0000);
    clear_counts(); send(9, 1'b0, 1'b1);
    check("t7_pd", 64'(n_pd), 64'(1));
    check("t7_le", 64'(n_le), 64'(1));
    check("t7_same_cycle", 64'(n_both), 64'(1));
    check("t7_count", 64'(pkt_count), 64'(1));
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
